// File: rtl/seq_det_pkg.sv
// Shared types and constants for the 11011 serial pattern detector.
package seq_det_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    S1     = 3'd1,
    S11    = 3'd2,
    S110   = 3'd3,
    S1101  = 3'd4,
    DETECT = 3'd5
  } state_t;

  localparam logic [4:0] PATTERN = 5'b11011;

endpackage

// File: rtl/seq_det_11011.sv
// Moore FSM that pulses dout for one cycle after the serial stream ends in 11011 (overlapping).
module seq_det_11011
  import seq_det_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  state_t r_state;
  state_t w_state_next;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = IDLE;
    unique case (r_state)
      IDLE:    w_state_next = din ? S1     : IDLE;
      S1:      w_state_next = din ? S11    : IDLE;
      S11:     w_state_next = din ? S11    : S110;
      S110:    w_state_next = din ? S1101  : IDLE;
      S1101:   w_state_next = din ? DETECT : IDLE;
      // Trailing "11" of a match seeds the next one.
      DETECT:  w_state_next = din ? S11    : S110;
      default: w_state_next = IDLE;
    endcase
  end

  assign dout = (r_state == DETECT);

endmodule

// File: tb/tb_seq_det_11011.sv
// Directed bench for seq_det_11011: drives one bit per cycle and checks dout after each edge.
module tb_seq_det_11011;
  import seq_det_pkg::*;

  logic clk;
  logic rst;
  logic din;
  logic dout;

  int total;
  int bad;

  seq_det_11011 dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .dout (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs on the falling edge, check dout 1 time unit after the rising edge.
  task automatic step(input logic r, input logic d, input logic exp, input string tag);
    @(negedge clk);
    rst = r;
    din = d;
    @(posedge clk);
    #1;
    total++;
    assert (dout === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, dout, exp);
    end
  endtask

  task automatic bit1(input logic d, input logic exp, input string tag);
    step(1'b1, d, exp, tag);
  endtask

  initial begin
    logic [4:0] pat;
    pat   = PATTERN;
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    din   = 1'b0;

    // Reset, then idle with zeros
    step(1'b0, 1'b0, 1'b0, "rst0");
    step(1'b0, 1'b0, 1'b0, "rst1");
    bit1(0, 0, "idle0");
    bit1(0, 0, "idle1");
    bit1(0, 0, "idle2");

    // Basic 11011 then 0
    for (int i = 4; i >= 0; i--) begin
      bit1(pat[i], (i == 0), "basic");
    end
    bit1(0, 0, "basic_clr");

    // Leading extra ones: 1,1,1,1,0,1,1,0 (state S110 on entry)
    bit1(0, 0, "pre_lead");
    bit1(1, 0, "lead1");
    bit1(1, 0, "lead2");
    bit1(1, 0, "lead3");
    bit1(1, 0, "lead4");
    bit1(0, 0, "lead5");
    bit1(1, 0, "lead6");
    bit1(1, 1, "lead7");
    bit1(0, 0, "lead8");

    // Near miss 1,0,0
    bit1(1, 0, "near1");
    bit1(0, 0, "near2");
    bit1(0, 0, "near3");

    // Recovery: 1,1,0,0,1,1,0,1,1,1,1,1,0,1,1
    bit1(1, 0, "rec1");
    bit1(1, 0, "rec2");
    bit1(0, 0, "rec3");
    bit1(0, 0, "rec4");
    bit1(1, 0, "rec5");
    bit1(1, 0, "rec6");
    bit1(0, 0, "rec7");
    bit1(1, 0, "rec8");
    bit1(1, 1, "rec9");
    bit1(1, 0, "rec10");
    bit1(1, 0, "rec11");
    bit1(1, 0, "rec12");
    bit1(0, 0, "rec13");
    bit1(1, 0, "rec14");
    bit1(1, 1, "rec15");

    // Flush back to IDLE, then overlap 1,1,0,1,1,0,1,1
    bit1(0, 0, "flush1");
    bit1(0, 0, "flush2");
    bit1(1, 0, "ovl1");
    bit1(1, 0, "ovl2");
    bit1(0, 0, "ovl3");
    bit1(1, 0, "ovl4");
    bit1(1, 1, "ovl5");
    bit1(0, 0, "ovl6");
    bit1(1, 0, "ovl7");
    bit1(1, 1, "ovl8");
    bit1(0, 0, "ovl_clr");
    bit1(0, 0, "ovl_idle");

    // Reset mid-sequence: 1,1,0,1 then reset with din=1 (reset wins), then din=1
    bit1(1, 0, "mid1");
    bit1(1, 0, "mid2");
    bit1(0, 0, "mid3");
    bit1(1, 0, "mid4");
    step(1'b0, 1'b1, 1'b0, "mid_rst");
    bit1(1, 0, "mid_after");
    for (int i = 4; i >= 0; i--) begin
      bit1(pat[i], (i == 0), "post_rst");
    end
    bit1(0, 0, "post_clr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
